// File: rtl/reg_file_sb.sv
// Parametrised register file with optional hardwired-zero register, write-to-read
// bypass and a per-register pending scoreboard that flags read-after-load hazards.
module reg_file_sb #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter bit ZERO_REG = 1'b0,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] IN,
   input  logic [ADDR_W-1:0] INADDR,
   input  logic              WRITEEN,
   input  logic              BUSYWAIT,
   input  logic [ADDR_W-1:0] OUT1ADD,
   input  logic [ADDR_W-1:0] OUT2ADD,
   output logic [DATA_W-1:0] OUT1,
   output logic [DATA_W-1:0] OUT2,
   input  logic              MARKEN,
   input  logic [ADDR_W-1:0] MARKADDR,
   output logic              HAZARD,
   output logic [ADDR_W:0]   PEND_CNT
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pend;
   logic [DEPTH-1:0]  pend_next;
   logic [ADDR_W:0]   cnt_next;
   logic              wcommit;
   logic              mcommit;
   logic              w_eff;
   logic              m_eff;
   logic              mark_over_write;
   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];
   logic [1:0]        rd_pend;

   assign wcommit = WRITEEN & ~BUSYWAIT & ~RESET;
   assign mcommit = MARKEN & ~BUSYWAIT & ~RESET;
   assign w_eff   = wcommit & ~(ZERO_REG && (INADDR == '0));
   assign m_eff   = mcommit & ~(ZERO_REG && (MARKADDR == '0));

   // Mark is applied after the write so a new load supersedes an old writeback.
   always_comb begin
      pend_next = pend;
      if (w_eff) pend_next[INADDR] = 1'b0;
      if (m_eff) pend_next[MARKADDR] = 1'b1;
      cnt_next = '0;
      for (int i = 0; i < DEPTH; i++)
         cnt_next = cnt_next + {{ADDR_W{1'b0}}, pend_next[i]};
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         pend     <= '0;
         PEND_CNT <= '0;
      end else begin
         if (w_eff) regs[INADDR] <= IN;
         pend     <= pend_next;
         PEND_CNT <= cnt_next;
      end
   end

   assign rd_addr[0]      = OUT1ADD;
   assign rd_addr[1]      = OUT2ADD;
   assign mark_over_write = mcommit & (MARKADDR == INADDR);

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = regs[rd_addr[p]];
         rd_pend[p] = pend[rd_addr[p]];
         if (BYPASS && wcommit && (INADDR == rd_addr[p])) begin
            rd_data[p] = IN;
            if (!mark_over_write) rd_pend[p] = 1'b0;
         end
         if (ZERO_REG && (rd_addr[p] == '0)) begin
            rd_data[p] = '0;
            rd_pend[p] = 1'b0;
         end
      end
   end

   assign OUT1   = rd_data[0];
   assign OUT2   = rd_data[1];
   assign HAZARD = ~RESET & (|rd_pend);

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: three configurations driven in lockstep and compared
// against an array-based model, plus directed scenarios with fixed expectations.
module tb_reg_file_sb;
   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        RESET, WRITEEN, BUSYWAIT, MARKEN;
   logic [15:0] in16;
   logic [3:0]  wa16, ma16, r1a16, r2a16;
   logic [7:0]  in8;
   logic [2:0]  wa8, ma8, r1a8, r2a8;
   logic [7:0]  o1_0, o2_0, o1_1, o2_1;
   logic [15:0] o1_2, o2_2;
   logic        hz_0, hz_1, hz_2;
   logic [3:0]  pc_0, pc_1;
   logic [4:0]  pc_2;

   assign in8  = in16[7:0];
   assign wa8  = wa16[2:0];
   assign ma8  = ma16[2:0];
   assign r1a8 = r1a16[2:0];
   assign r2a8 = r2a16[2:0];

   reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut0 (
      .CLK(CLK), .RESET(RESET), .IN(in8), .INADDR(wa8), .WRITEEN(WRITEEN),
      .BUSYWAIT(BUSYWAIT), .OUT1ADD(r1a8), .OUT2ADD(r2a8), .OUT1(o1_0), .OUT2(o2_0),
      .MARKEN(MARKEN), .MARKADDR(ma8), .HAZARD(hz_0), .PEND_CNT(pc_0));

   reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut1 (
      .CLK(CLK), .RESET(RESET), .IN(in8), .INADDR(wa8), .WRITEEN(WRITEEN),
      .BUSYWAIT(BUSYWAIT), .OUT1ADD(r1a8), .OUT2ADD(r2a8), .OUT1(o1_1), .OUT2(o2_1),
      .MARKEN(MARKEN), .MARKADDR(ma8), .HAZARD(hz_1), .PEND_CNT(pc_1));

   reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut2 (
      .CLK(CLK), .RESET(RESET), .IN(in16), .INADDR(wa16), .WRITEEN(WRITEEN),
      .BUSYWAIT(BUSYWAIT), .OUT1ADD(r1a16), .OUT2ADD(r2a16), .OUT1(o1_2), .OUT2(o2_2),
      .MARKEN(MARKEN), .MARKADDR(ma16), .HAZARD(hz_2), .PEND_CNT(pc_2));

   always @(posedge CLK)
      if (WRITEEN && !BUSYWAIT && !RESET)
         assert (!$isunknown(in16)) else $error("FAIL in_known: IN unknown on a committing write");

   int m_regs [3][16];
   bit m_pend [3][16];
   int dmask  [3] = '{255, 255, 65535};
   int amask  [3] = '{7, 7, 15};
   bit zr     [3] = '{1'b0, 1'b1, 1'b0};
   bit byp    [3] = '{1'b1, 1'b0, 1'b1};
   int n_vec = 0;
   int n_err = 0;
   bit t_rst, t_we, t_bw, t_me;
   int t_in, t_wa, t_ma, t_r1, t_r2;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int exp_rd(int k, int a);
      int wa = t_wa & amask[k];
      bit wc = t_we && !t_bw && !t_rst;
      if (zr[k] && a == 0) return 0;
      if (byp[k] && wc && wa == a) return t_in & dmask[k];
      return m_regs[k][a];
   endfunction

   function automatic bit exp_p(int k, int a);
      int wa = t_wa & amask[k];
      int ma = t_ma & amask[k];
      bit wc = t_we && !t_bw && !t_rst;
      bit mc = t_me && !t_bw && !t_rst;
      if (t_rst || (zr[k] && a == 0)) return 1'b0;
      if (byp[k] && wc && wa == a && !(mc && ma == wa)) return 1'b0;
      return m_pend[k][a];
   endfunction

   function automatic int pcount(int k);
      int n = 0;
      for (int i = 0; i < 16; i++) n += int'(m_pend[k][i]);
      return n;
   endfunction

   // Drive one cycle's inputs after the falling edge and check every DUT before the rising edge.
   task automatic apply(input bit rst, we, bw, me, input int in, wa, ma, r1, r2);
      @(negedge CLK);
      t_rst = rst; t_we = we; t_bw = bw; t_me = me;
      t_in = in; t_wa = wa; t_ma = ma; t_r1 = r1; t_r2 = r2;
      RESET = rst; WRITEEN = we; BUSYWAIT = bw; MARKEN = me;
      in16 = 16'(in); wa16 = 4'(wa); ma16 = 4'(ma); r1a16 = 4'(r1); r2a16 = 4'(r2);
      #1;
      for (int k = 0; k < 3; k++) begin
         logic [15:0] a1, a2;
         logic        ah;
         logic [4:0]  ap;
         int          x1, x2;
         case (k)
            0:       begin a1 = 16'(o1_0); a2 = 16'(o2_0); ah = hz_0; ap = 5'(pc_0); end
            1:       begin a1 = 16'(o1_1); a2 = 16'(o2_1); ah = hz_1; ap = 5'(pc_1); end
            default: begin a1 = o1_2;      a2 = o2_2;      ah = hz_2; ap = pc_2;     end
         endcase
         x1 = t_r1 & amask[k];
         x2 = t_r2 & amask[k];
         check_val($sformatf("dut%0d_out1", k), 32'(a1), exp_rd(k, x1));
         check_val($sformatf("dut%0d_out2", k), 32'(a2), exp_rd(k, x2));
         check_val($sformatf("dut%0d_hazard", k), 32'(ah), 32'(exp_p(k, x1) | exp_p(k, x2)));
         check_val($sformatf("dut%0d_pend_cnt", k), 32'(ap), pcount(k));
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      for (int k = 0; k < 3; k++) begin
         int wa = t_wa & amask[k];
         int ma = t_ma & amask[k];
         bit wc = t_we && !t_bw && !t_rst;
         bit mc = t_me && !t_bw && !t_rst;
         if (t_rst) begin
            for (int i = 0; i < 16; i++) begin
               m_regs[k][i] = 0;
               m_pend[k][i] = 1'b0;
            end
         end else begin
            if (wc && !(zr[k] && wa == 0)) begin
               m_regs[k][wa] = t_in & dmask[k];
               m_pend[k][wa] = 1'b0;
            end
            if (mc && !(zr[k] && ma == 0)) m_pend[k][ma] = 1'b1;
         end
      end
   endtask

   task automatic idle(input int r1, r2);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, r1, r2);
   endtask

   initial begin
      RESET = 1'b1; WRITEEN = 1'b0; BUSYWAIT = 1'b0; MARKEN = 1'b0;
      in16 = '0; wa16 = '0; ma16 = '0; r1a16 = '0; r2a16 = '0;

      apply(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0); tick();
      idle(1, 2); check_val("init_pend_cnt", 32'(pc_0), 0); tick();

      // reset clears preloaded data and an outstanding load
      for (int i = 1; i < 8; i++) begin
         apply(1'b0, 1'b1, 1'b0, 1'b0, i * 17, i, 0, 0, 0); tick();
      end
      apply(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 3, 0, 0); tick();
      idle(3, 7);
      check_val("pre_rst_hazard", 32'(hz_0), 1);
      check_val("pre_rst_r7", 32'(o2_0), 32'h77);
      tick();
      apply(1'b1, 1'b1, 1'b0, 1'b1, 8'hEE, 3, 3, 3, 7);
      check_val("in_rst_hazard", 32'(hz_0), 0);
      tick();
      idle(3, 7);
      check_val("rst_out1", 32'(o1_0), 0);
      check_val("rst_out2", 32'(o2_0), 0);
      check_val("rst_hazard", 32'(hz_0), 0);
      check_val("rst_pend_cnt", 32'(pc_0), 0);
      tick();

      // write/read, bypass and stall
      apply(1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 2, 0, 2, 0);
      check_val("bypass_out1", 32'(o1_0), 32'hA5);
      check_val("nobypass_out1", 32'(o1_1), 0);
      tick();
      idle(2, 0);
      check_val("wr_out1", 32'(o1_0), 32'hA5);
      check_val("wr_nobyp_out1", 32'(o1_1), 32'hA5);
      tick();
      apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 2, 0, 2, 0);
      check_val("stall_byp_out1", 32'(o1_0), 32'hA5);
      tick();
      idle(2, 0); check_val("stall_out1", 32'(o1_0), 32'hA5); tick();

      // zero register
      apply(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 0, 0, 0, 0); tick();
      idle(0, 0);
      check_val("zr_out1", 32'(o1_1), 0);
      check_val("zr_hazard", 32'(hz_1), 0);
      check_val("zr_pend_cnt", 32'(pc_1), 0);
      tick();
      apply(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0); tick();

      // load hazard and writeback
      apply(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 5, 0, 0); tick();
      for (int c = 0; c < 3; c++) begin
         idle(0, 5);
         check_val("load_hazard", 32'(hz_0), 1);
         check_val("load_pend_cnt", 32'(pc_0), 1);
         tick();
      end
      apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h9E, 5, 0, 0, 5);
      check_val("wb_hazard", 32'(hz_0), 0);
      check_val("wb_out2", 32'(o2_0), 32'h9E);
      check_val("wb_nobyp_hazard", 32'(hz_1), 1);
      tick();
      idle(0, 5);
      check_val("wb_pend_cnt", 32'(pc_0), 0);
      check_val("wb_after_out2", 32'(o2_0), 32'h9E);
      tick();

      // same-cycle mark and write on the same register
      apply(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 4, 0, 0); tick();
      apply(1'b0, 1'b1, 1'b0, 1'b1, 8'h42, 4, 4, 4, 0);
      check_val("mw_hazard", 32'(hz_0), 1);
      tick();
      idle(4, 0);
      check_val("mw_out1", 32'(o1_0), 32'h42);
      check_val("mw_after_hazard", 32'(hz_0), 1);
      check_val("mw_pend_cnt", 32'(pc_0), 1);
      tick();

      // full scoreboard on the 16-entry instance
      apply(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0); tick();
      for (int i = 0; i < 16; i++) begin
         apply(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, i, 0, 0); tick();
      end
      idle(0, 0); check_val("full_pend_cnt", 32'(pc_2), 16); tick();
      apply(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 7, 0, 0); tick();
      idle(0, 0); check_val("remark_pend_cnt", 32'(pc_2), 16); tick();
      apply(1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 7, 0, 0, 0); tick();
      idle(0, 0); check_val("wr7_pend_cnt", 32'(pc_2), 15); tick();
      apply(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0); tick();
      idle(0, 0); check_val("full_rst_pend_cnt", 32'(pc_2), 0); tick();

      for (int n = 0; n < 2000; n++) begin
         apply($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
               int'($urandom_range(0, 65535)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
